lz_normalize_pipe: RTL and testbench

Parametrised, pipelined normaliser for the floating-point adder datapath. Takes the raw adder sum and its pre-normalisation exponent, counts leading zeros, left-shifts the mantissa and adjusts the exponent. It adds zero detection, exponent-underflow clamping and a valid/ready handshake with backpressure. It sits between the significand adder and the rounding stage, and fixes the fixed-width 26-bit, combinational-only leading-zero encoder.

---
 rtl/lz_normalize_pipe.sv | 120 ++++++++++++
 tb/tb_lz_normalize_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lz_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lz_normalize_pipe
// Description : Two-stage leading-zero normaliser for the FP adder datapath.
//               Count stage, then shift/adjust stage, with valid/ready flow.
// Revision    : 1.0 - initial release
// ============================================================================
module lz_normalize_pipe #(
    parameter int WIDTH = 26,
    parameter int EXP_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [CNT_W-1:0] out_shift,
    output logic             out_zero,
    output logic             out_underflow
);

    localparam int MW = (CNT_W > EXP_W) ? CNT_W : EXP_W;

    if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_w_check
        $error("lz_normalize_pipe: CNT_W too small to encode a shift of WIDTH");
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_sum;
    logic [EXP_W-1:0] s1_exp;
    logic [CNT_W-1:0] s1_lz;
    logic             s1_zero;

    logic             s2_free;
    logic             s1_advance;
    logic             in_accept;

    logic [CNT_W-1:0] lz_c;
    logic [MW-1:0]    lz_ext;
    logic [MW-1:0]    exp_ext;
    logic [MW-1:0]    eff_ext;
    logic [CNT_W-1:0] eff_cnt;

    assign s2_free    = !out_valid || out_ready;
    assign in_ready   = rst_n && (!s1_valid || s2_free);
    assign in_accept  = in_valid && in_ready;
    assign s1_advance = s1_valid && s2_free;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        lz_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_sum[i]) begin
                lz_c = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    // Shift is clamped to the exponent so the adjusted exponent never wraps.
    assign lz_ext  = MW'(s1_lz);
    assign exp_ext = MW'(s1_exp);
    assign eff_ext = (lz_ext < exp_ext) ? lz_ext : exp_ext;
    assign eff_cnt = CNT_W'(eff_ext);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_sum        <= '0;
            s1_exp        <= '0;
            s1_lz         <= '0;
            s1_zero       <= 1'b0;
            out_valid     <= 1'b0;
            out_mant      <= '0;
            out_exp       <= '0;
            out_shift     <= '0;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            if (in_accept) begin
                s1_sum  <= in_sum;
                s1_exp  <= in_exp;
                s1_lz   <= lz_c;
                s1_zero <= (in_sum == '0);
            end

            if (in_accept) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end

            if (s1_advance) begin
                out_valid <= 1'b1;
                if (s1_zero) begin
                    out_mant      <= '0;
                    out_exp       <= '0;
                    out_shift     <= CNT_W'(WIDTH);
                    out_zero      <= 1'b1;
                    out_underflow <= 1'b0;
                end else begin
                    out_mant      <= s1_sum << eff_cnt;
                    out_exp       <= EXP_W'(exp_ext - eff_ext);
                    out_shift     <= eff_cnt;
                    out_zero      <= 1'b0;
                    out_underflow <= (lz_ext > exp_ext);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lz_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lz_normalize_pipe
// Description : Scoreboard bench for lz_normalize_pipe with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lz_normalize_pipe;

    localparam int W  = 26;
    localparam int EW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_sum = '0;
    logic [EW-1:0] in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_mant;
    logic [EW-1:0] out_exp;
    logic [CW-1:0] out_shift;
    logic          out_zero;
    logic          out_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0]  mant;
        logic [EW-1:0] ex;
        logic [CW-1:0] sh;
        logic          z;
        logic          uf;
    } exp_t;

    exp_t q[$];

    lz_normalize_pipe #(.WIDTH(W), .EXP_W(EW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sum        (in_sum),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_shift     (out_shift),
        .out_zero      (out_zero),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: bit length via $clog2, shift as multiplication modulo 2^W.
    function automatic exp_t model(input logic [W-1:0] s, input logic [EW-1:0] e);
        exp_t r;
        longint unsigned sv, ev, bl, lz, eff;
        sv = 64'(s);
        ev = 64'(e);
        if (sv == 0) begin
            r.mant = '0; r.ex = '0; r.sh = CW'(W); r.z = 1'b1; r.uf = 1'b0;
        end else begin
            bl  = 64'($clog2(sv + 1));
            lz  = W - bl;
            eff = (lz < ev) ? lz : ev;
            r.mant = W'((sv * (64'd1 << eff)) % (64'd1 << W));
            r.ex   = EW'(ev - eff);
            r.sh   = CW'(eff);
            r.z    = 1'b0;
            r.uf   = (lz > ev);
        end
        return r;
    endfunction

    // Scoreboard/monitor: front of queue must be on the outputs whenever valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_mant", out_mant, q[0].mant);
                    chk("out_exp", out_exp, q[0].ex);
                    chk("out_shift", out_shift, q[0].sh);
                    chk("out_zero", out_zero, q[0].z);
                    chk("out_underflow", out_underflow, q[0].uf);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_sum, in_exp));
        end
    end

    // One clock cycle: drive after the edge, return at the following negedge.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] s,
                         input logic [EW-1:0] e, input logic ordy, output logic acc);
        @(posedge clk);
        #1;
        rst_n     = r;
        in_valid  = v;
        in_sum    = s;
        in_exp    = e;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready && rst_n;
    endtask

    task automatic directed(input logic [W-1:0] s, input logic [EW-1:0] e);
        logic acc;
        cycle(1, 1, s, e, 1, acc);
        chk("directed_accept", acc, 1);
        cycle(1, 0, '0, '0, 1, acc);
        chk("latency_not_early", out_valid, 0);
        cycle(1, 0, '0, '0, 1, acc);
        chk("latency_two", out_valid, 1);
        cycle(1, 0, '0, '0, 1, acc);
    endtask

    logic [W-1:0]  cur_sum;
    logic [EW-1:0] cur_exp;

    task automatic new_data();
        int k;
        k = $urandom_range(0, W);
        if (k == W) cur_sum = '0;
        else cur_sum = W'((64'd1 << k) | (64'($urandom) & ((64'd1 << k) - 1)));
        if ($urandom_range(0, 1) == 0) cur_exp = EW'($urandom_range(0, 30));
        else cur_exp = EW'($urandom);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   waited;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, '0, 1, acc);
            chk("reset_in_ready", in_ready, 0);
        end
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_mant", out_mant, 0);
        chk("reset_out_exp", out_exp, 0);
        chk("reset_out_shift", out_shift, 0);
        chk("reset_flags", {out_zero, out_underflow}, 0);
        cycle(1, 0, '0, '0, 1, acc);
        chk("post_reset_in_ready", in_ready, 1);

        // Directed vectors from the block's test plan
        directed(26'h2000000, 8'd100);
        directed(26'h0000001, 8'd100);
        directed(26'h0000000, 8'd50);
        directed(26'h0000100, 8'd10);
        directed(26'h3FFFFFF, 8'd0);

        // Backpressure: six beats, out_ready low in cycles 3..6
        sent = 0;
        for (int c = 1; c <= 14; c++) begin
            cycle(1, sent < 6, W'(26'h0000400 + 64'(c)), EW'(8 + c), !(c >= 3 && c <= 6), acc);
            if (acc) sent++;
            if (c >= 3 && c <= 6) chk("bp_in_ready_full", in_ready, 0);
            if (c == 7) chk("bp_in_ready_release", in_ready, 1);
            if (c >= 7 && c <= 12) chk("bp_back_to_back", out_valid, 1);
        end
        chk("bp_all_sent", sent, 6);
        cycle(1, 0, '0, '0, 1, acc);

        // Reset with two beats in flight
        cycle(1, 1, 26'h0001234, 8'd40, 0, acc);
        cycle(1, 1, 26'h0000077, 8'd3, 0, acc);
        cycle(0, 0, '0, '0, 0, acc);
        chk("midrst_in_ready", in_ready, 0);
        cycle(1, 0, '0, '0, 1, acc);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {out_mant, out_exp, out_shift, out_zero, out_underflow}, 0);
        chk("midrst_in_ready_back", in_ready, 1);
        cycle(1, 0, '0, '0, 1, acc);
        chk("midrst_no_stale", out_valid, 0);
        directed(26'h0000020, 8'd30);

        // Randomised traffic with random backpressure
        new_data();
        for (int c = 0; c < 600; c++) begin
            cycle(1, ($urandom % 4) != 0, cur_sum, cur_exp, ($urandom % 4) != 0, acc);
            if (acc) new_data();
        end

        // Drain with a bounded wait
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            cycle(1, 0, '0, '0, 1, acc);
            waited++;
        end
        chk("drain_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
